// File: rtl/decode_nx_seq.sv
// rtl/decode_nx_seq.sv - registered SEL_W-to-2^SEL_W decoder with select handshake and walking-one scan
// Optional feature macro: DECODE_OUT_INV_EN (y driven active-low, one-cold).
module decode_nx_seq #(
    parameter int SEL_W    = 2,
    parameter int SCAN_DIV = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic                  sel_valid,
    output logic                  sel_ready,
    input  logic [SEL_W-1:0]      sel,
    output logic [(2**SEL_W)-1:0] y,
    output logic [SEL_W-1:0]      y_idx,
    output logic                  y_valid,
    output logic                  wrap
);
    localparam int OUT_W = 2**SEL_W;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

`ifdef DECODE_OUT_INV_EN
    localparam logic Y_POL = 1'b1;
`else
    localparam logic Y_POL = 1'b0;
`endif

    typedef enum logic [1:0] {
        MODE_DECODE = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    mode_t             cur_mode;
    mode_t             last_mode_q, last_mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  idx_d;
    logic              valid_d;
    logic              wrap_d;
    logic [OUT_W-1:0]  onehot_d;
    logic [OUT_W-1:0]  y_d;

    assign cur_mode  = mode_t'(mode);
    assign sel_ready = en && (cur_mode == MODE_DECODE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y           <= {OUT_W{Y_POL}};
            y_idx       <= '0;
            y_valid     <= 1'b0;
            wrap        <= 1'b0;
            cnt_q       <= '0;
            last_mode_q <= MODE_DECODE;
        end else begin
            y           <= y_d;
            y_idx       <= idx_d;
            y_valid     <= valid_d;
            wrap        <= wrap_d;
            cnt_q       <= cnt_d;
            last_mode_q <= last_mode_d;
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = y_idx;
        valid_d     = y_valid;
        wrap_d      = 1'b0;
        last_mode_d = last_mode_q;
        if (en) begin
            last_mode_d = cur_mode;
            if (cur_mode == MODE_DECODE) begin
                cnt_d = '0;
                if (sel_valid) begin
                    idx_d   = sel;
                    valid_d = 1'b1;
                end
            end else if (cur_mode != last_mode_q) begin
                // Mode switch restarts the prescaler but keeps the current line.
                cnt_d = '0;
            end else if (cur_mode != MODE_HOLD) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!y_valid) begin
                        valid_d = 1'b1;
                        idx_d   = (cur_mode == MODE_UP) ? '0 : '1;
                    end else if (cur_mode == MODE_UP) begin
                        idx_d  = y_idx + SEL_W'(1);
                        wrap_d = (y_idx == '1);
                    end else begin
                        idx_d  = y_idx - SEL_W'(1);
                        wrap_d = (y_idx == '0);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        onehot_d = '0;
        if (valid_d) onehot_d[idx_d] = 1'b1;
        y_d = onehot_d ^ {OUT_W{Y_POL}};
    end

endmodule

// File: tb/tb_decode_nx_seq.sv
// tb/tb_decode_nx_seq.sv - directed self-checking bench for decode_nx_seq (SEL_W=2/SCAN_DIV=3 and SEL_W=1/SCAN_DIV=1)
module tb_decode_nx_seq;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, sel_valid, sel_ready, y_valid, wrap;
    logic [1:0] mode, sel, y_idx;
    logic [3:0] y;

    logic       b_en, b_sel_valid, b_sel_ready, b_sel, b_y_idx, b_y_valid, b_wrap;
    logic [1:0] b_mode, b_y;

    int checks = 0;
    int passes = 0;

    logic [7:0] obs_a, exp_a;
    logic [4:0] obs_b, exp_b;
    assign obs_a = {y, y_idx, y_valid, wrap};
    assign obs_b = {b_y, b_y_idx, b_y_valid, b_wrap};

    decode_nx_seq #(.SEL_W(2), .SCAN_DIV(3)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_valid(sel_valid),
        .sel_ready(sel_ready), .sel(sel), .y(y), .y_idx(y_idx),
        .y_valid(y_valid), .wrap(wrap)
    );

    decode_nx_seq #(.SEL_W(1), .SCAN_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .en(b_en), .mode(b_mode), .sel_valid(b_sel_valid),
        .sel_ready(b_sel_ready), .sel(b_sel), .y(b_y), .y_idx(b_y_idx),
        .y_valid(b_y_valid), .wrap(b_wrap)
    );

    function automatic logic [7:0] pack_a(input int idx, input logic v, input logic w);
        logic [3:0] yy;
        yy = v ? 4'(1 << idx) : 4'b0000;
`ifdef DECODE_OUT_INV_EN
        yy = ~yy;
`endif
        return {yy, 2'(idx), v, w};
    endfunction

    function automatic logic [4:0] pack_b(input int idx, input logic v, input logic w);
        logic [1:0] yy;
        yy = v ? 2'(1 << idx) : 2'b00;
`ifdef DECODE_OUT_INV_EN
        yy = ~yy;
`endif
        return {yy, 1'(idx), v, w};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick;
        tick;
        exp_a = pack_a(0, 0, 0);
        checks++; if (obs_a !== exp_a) $display("FAIL reset_a obs=%b exp=%b", obs_a, exp_a); else passes++;
        exp_b = pack_b(0, 0, 0);
        checks++; if (obs_b !== exp_b) $display("FAIL reset_b obs=%b exp=%b", obs_b, exp_b); else passes++;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_decode;
        en = 1'b1; mode = 2'b00; sel_valid = 1'b1; sel = 2'd2;
        #1;
        checks++; if (sel_ready !== 1'b1) $display("FAIL ready_decode obs=%b exp=1", sel_ready); else passes++;
        exp_a = pack_a(0, 0, 0);
        checks++; if (obs_a !== exp_a) $display("FAIL decode_pre obs=%b exp=%b", obs_a, exp_a); else passes++;
        tick;
        exp_a = pack_a(2, 1, 0);
        checks++; if (obs_a !== exp_a) $display("FAIL decode_sel2 obs=%b exp=%b", obs_a, exp_a); else passes++;
        sel = 2'd1;
        tick;
        exp_a = pack_a(1, 1, 0);
        checks++; if (obs_a !== exp_a) $display("FAIL decode_sel1 obs=%b exp=%b", obs_a, exp_a); else passes++;
        sel_valid = 1'b0; sel = 2'd3;
        tick;
        checks++; if (obs_a !== exp_a) $display("FAIL decode_no_xfer obs=%b exp=%b", obs_a, exp_a); else passes++;
    endtask

    task automatic test_handshake;
        mode = 2'b01; sel_valid = 1'b1; sel = 2'd3;
        #1;
        checks++; if (sel_ready !== 1'b0) $display("FAIL ready_scan obs=%b exp=0", sel_ready); else passes++;
        tick;
        exp_a = pack_a(1, 1, 0);
        checks++; if (obs_a !== exp_a) $display("FAIL scan_ignores_sel obs=%b exp=%b", obs_a, exp_a); else passes++;
        en = 1'b0; mode = 2'b00;
        #1;
        checks++; if (sel_ready !== 1'b0) $display("FAIL ready_en0 obs=%b exp=0", sel_ready); else passes++;
        tick; tick; tick;
        checks++; if (obs_a !== exp_a) $display("FAIL en0_hold obs=%b exp=%b", obs_a, exp_a); else passes++;
        sel_valid = 1'b0;
    endtask

    task automatic test_scan_up;
        int seq [5];
        seq = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        tick;
        rst = 1'b0;
        en = 1'b1; mode = 2'b01;
        tick;
        for (int k = 0; k < 5; k++) begin
            tick;
            tick;
            exp_a = (k == 0) ? pack_a(0, 0, 0) : pack_a(seq[k-1], 1, 0);
            checks++; if (obs_a !== exp_a) $display("FAIL scan_up_wait%0d obs=%b exp=%b", k, obs_a, exp_a); else passes++;
            tick;
            exp_a = pack_a(seq[k], 1, (k == 4));
            checks++; if (obs_a !== exp_a) $display("FAIL scan_up_step%0d obs=%b exp=%b", k, obs_a, exp_a); else passes++;
        end
        tick;
        exp_a = pack_a(0, 1, 0);
        checks++; if (obs_a !== exp_a) $display("FAIL scan_up_wrap_len obs=%b exp=%b", obs_a, exp_a); else passes++;
    endtask

    task automatic test_scan_down_switch;
        tick; tick;
        exp_a = pack_a(1, 1, 0);
        checks++; if (obs_a !== exp_a) $display("FAIL pre_down_idx1 obs=%b exp=%b", obs_a, exp_a); else passes++;
        mode = 2'b10;
        tick;
        checks++; if (obs_a !== exp_a) $display("FAIL down_switch_nostep obs=%b exp=%b", obs_a, exp_a); else passes++;
        tick; tick; tick;
        exp_a = pack_a(0, 1, 0);
        checks++; if (obs_a !== exp_a) $display("FAIL down_1to0 obs=%b exp=%b", obs_a, exp_a); else passes++;
        tick; tick; tick;
        exp_a = pack_a(3, 1, 1);
        checks++; if (obs_a !== exp_a) $display("FAIL down_0to3 obs=%b exp=%b", obs_a, exp_a); else passes++;
        tick;
        mode = 2'b01;
        tick;
        exp_a = pack_a(3, 1, 0);
        checks++; if (obs_a !== exp_a) $display("FAIL up_switch_nostep obs=%b exp=%b", obs_a, exp_a); else passes++;
        tick; tick;
        checks++; if (obs_a !== exp_a) $display("FAIL up_switch_cnt_clr obs=%b exp=%b", obs_a, exp_a); else passes++;
        tick;
        exp_a = pack_a(0, 1, 1);
        checks++; if (obs_a !== exp_a) $display("FAIL up_3to0 obs=%b exp=%b", obs_a, exp_a); else passes++;
    endtask

    task automatic test_hold_enable;
        tick;
        mode = 2'b11;
        exp_a = pack_a(0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            tick;
            checks++; if (obs_a !== exp_a) $display("FAIL hold_cyc%0d obs=%b exp=%b", i, obs_a, exp_a); else passes++;
        end
        mode = 2'b01;
        tick;
        tick;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            checks++; if (obs_a !== exp_a) $display("FAIL en0_cyc%0d obs=%b exp=%b", i, obs_a, exp_a); else passes++;
        end
        en = 1'b1;
        tick;
        checks++; if (obs_a !== exp_a) $display("FAIL en_resume_cnt obs=%b exp=%b", obs_a, exp_a); else passes++;
        tick;
        exp_a = pack_a(1, 1, 0);
        checks++; if (obs_a !== exp_a) $display("FAIL en_resume_step obs=%b exp=%b", obs_a, exp_a); else passes++;
    endtask

    task automatic test_async_reset;
        #2;
        rst = 1'b1;
        #1;
        exp_a = pack_a(0, 0, 0);
        checks++; if (obs_a !== exp_a) $display("FAIL async_rst_now obs=%b exp=%b", obs_a, exp_a); else passes++;
        tick;
        checks++; if (obs_a !== exp_a) $display("FAIL async_rst_held obs=%b exp=%b", obs_a, exp_a); else passes++;
        rst = 1'b0;
        mode = 2'b10;
        tick;
        tick; tick;
        checks++; if (obs_a !== exp_a) $display("FAIL post_rst_wait obs=%b exp=%b", obs_a, exp_a); else passes++;
        tick;
        exp_a = pack_a(3, 1, 0);
        checks++; if (obs_a !== exp_a) $display("FAIL post_rst_load obs=%b exp=%b", obs_a, exp_a); else passes++;
    endtask

    task automatic test_out_w2;
        int idx_t [8];
        int val_t [8];
        int wrp_t [8];
        idx_t = '{0, 0, 1, 0, 1, 1, 0, 1};
        val_t = '{0, 1, 1, 1, 1, 1, 1, 1};
        wrp_t = '{0, 0, 0, 1, 0, 0, 0, 1};
        b_en = 1'b1; b_mode = 2'b01;
        #1;
        checks++; if (b_sel_ready !== 1'b0) $display("FAIL b_ready_scan obs=%b exp=0", b_sel_ready); else passes++;
        for (int k = 0; k < 8; k++) begin
            if (k == 5) b_mode = 2'b10;
            tick;
            exp_b = pack_b(idx_t[k], val_t[k][0], wrp_t[k][0]);
            checks++; if (obs_b !== exp_b) $display("FAIL w2_cyc%0d obs=%b exp=%b", k, obs_b, exp_b); else passes++;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; sel_valid = 1'b0; sel = 2'd0;
        b_en = 1'b0; b_mode = 2'b00; b_sel_valid = 1'b0; b_sel = 1'b0;
        test_reset;
        test_decode;
        test_handshake;
        test_scan_up;
        test_scan_down_switch;
        test_hold_enable;
        test_async_reset;
        test_out_w2;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/decode_nx_seq.md
Name: decode_nx_seq

Overview:
- Parametrised successor to the team's 2-to-4 decoder: SEL_W-bit select to 2^SEL_W one-hot output, with registered outputs.
- Adds a valid/ready select handshake and two scan modes: a walking one-hot that steps up or down with a programmable prescaler, plus a wrap pulse.
- Used as a registered chip-select, row-select or display-digit-scan driver.

Parameters:
- SEL_W, 2, select width; OUT_W = 2**SEL_W output lines (SEL_W >= 1).
- SCAN_DIV, 1, clk cycles per scan step (>= 1); prescaler width = clog2(SCAN_DIV), minimum 1 bit.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; when 0, all state holds.
- mode  in  2  00 decode, 01 scan-up, 10 scan-down, 11 hold.
- sel_valid  in  1  select request.
- sel_ready  out  1  combinational: en && (mode == 00).
- sel  in  SEL_W  select index.
- y  out  OUT_W  registered one-hot output.
- y_idx  out  SEL_W  registered binary index of the active line.
- y_valid  out  1  y holds a valid one-hot value.
- wrap  out  1  one-cycle pulse on scan wrap-around.

Behaviour:
- Reset (asynchronous, active-high) clears everything:
  - y = 0, y_idx = 0, y_valid = 0, wrap = 0.
  - Prescaler cnt = 0, internal last_mode = 00.
  - Outputs stay at these values while rst is high.
- Invariant: when y_valid = 1, y == (1 << y_idx), exactly one bit set. When y_valid = 0, y = 0.
- en = 0:
  - All registers hold and sel_ready = 0.
  - wrap is registered and forced to 0 on any cycle without a step.
- Decode mode (00):
  - A transfer occurs when sel_valid && sel_ready.
  - Next edge: y = 1 << sel, y_idx = sel, y_valid = 1. Latency is 1 cycle.
  - No transfer: y, y_idx and y_valid hold.
  - cnt is held at 0. wrap = 0.
- Scan modes (01/10), each en cycle:
  - If cnt == SCAN_DIV-1: step and set cnt = 0. Otherwise cnt++ and no step.
  - Step with y_valid = 0: load start index (0 for up, OUT_W-1 for down), set y_valid = 1, no wrap.
  - Step up: y_idx = y_idx + 1 modulo OUT_W. wrap = 1 for that cycle when moving OUT_W-1 -> 0.
  - Step down: y_idx = y_idx - 1 modulo OUT_W. wrap = 1 when moving 0 -> OUT_W-1.
  - sel / sel_valid are ignored.
  - With SCAN_DIV = 1, a step occurs every en cycle.
- Hold mode (11): y, y_idx, y_valid and cnt freeze; wrap = 0.
- Mode change:
  - Detected as mode != last_mode on an en cycle.
  - cnt is cleared to 0 on that cycle; no step occurs that cycle.
  - The current index is kept, so scanning resumes from the current line.
  - last_mode updates only on en cycles.
- Up<->down switch:
  - The index continues from its current value.
  - wrap fires only on an actual boundary crossing.
- OUT_W = 2 (SEL_W = 1): scan toggles between the two lines, and every step that crosses a boundary pulses wrap.
- Reset mid-scan: immediate return to reset values; the first post-reset scan step loads the start index.

Optional Feature:
- Macro DECODE_OUT_INV_EN.
- Defined:
  - y is driven active-low: a one-cold output, with reset/invalid value all ones.
  - The active line is the 0 bit; y_idx, y_valid and wrap are unchanged.
- Undefined: active-high one-hot exactly as above; reset value all zeros.

Test Plan:
- Reset/decode: SEL_W = 2, assert rst, release, then en = 1, mode = 00, sel_valid = 1, sel = 2 -> before the edge y = 0000, y_valid = 0; next cycle y = 0100, y_idx = 2, y_valid = 1.
- Handshake: mode = 01 with sel_valid = 1, sel = 3 -> sel_ready = 0, sel ignored. Then en = 0, mode = 00 -> sel_ready = 0, outputs hold.
- Scan up: SCAN_DIV = 3 from reset, mode = 01, en = 1 ->
  - steps occur every 3 cycles;
  - sequence 0001 (load), 0010, 0100, 1000, 0001;
  - wrap = 1 for exactly the cycle y returns to 0001.
- Scan down and switch:
  - mode = 10 from a y_idx = 1 state -> next steps are 1->0, then 0->3 with wrap = 1.
  - Switching to 01 mid-count clears cnt; the next step occurs SCAN_DIV en cycles later.
- Hold/enable: mode = 11 for 10 cycles, then en = 0 for 10 cycles mid-scan -> y, y_idx and cnt are unchanged and wrap = 0 throughout.
- Async reset mid-scan (asserted between clock edges) plus DECODE_OUT_INV_EN build:
  - outputs return to reset immediately: y = 1111 inverted, 0000 otherwise;
  - inverted build decodes sel = 1 to y = 1101.
